// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage.
//   ADDR_W_DEF / INSTR_W_DEF : default PC and instruction widths
//   fetch_state_e            : fetch FSM states (ST_BOOT, ST_RUN)
//   fetch_entry_t            : queue entry {instr, pc} at default widths
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF  = 9;
    localparam int unsigned INSTR_W_DEF = 32;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO for tagged fetch results.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, wdata  : write one entry
//   pop          : drop the head entry
//   flush        : empty the FIFO at the edge; wins over push
//   count        : current occupancy (0..DEPTH)
//   head         : entry at the read pointer
//   full, empty  : occupancy flags
module fetch_fifo #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [PTR_W:0]   wr_q;
    logic [PTR_W:0]   rd_q;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            mem_q[wr_q[PTR_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        count = wr_q - rd_q;
        empty = (wr_q == rd_q);
        full  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
        head  = mem_q[rd_q[PTR_W-1:0]];
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage between the program counter and decode.
// Drives the counter (CE / load), issues instruction-memory reads, tags each
// response with its PC and buffers it for decode.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   pc                  : current counter value
//   pc_ce, pc_load      : counter enable / load
//   pc_load_addr        : counter load value (boot vector or redirect target)
//   imem_rd, imem_addr  : read strobe and address (address = pc)
//   imem_data           : read data, valid one cycle after imem_rd
//   redirect(_addr)     : branch/jump taken pulse and target
//   out_valid/out_ready : decode handshake
//   out_instr, out_pc   : head instruction and its PC
// Build option: FETCH_QUEUE_BYPASS_EN lets a response arriving at an empty queue
// drive out_* in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_ce,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_load_addr,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] tag_q;

    logic              credit;
    logic              fetch;
    logic              redirect_run;
    logic              resp_live;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [ENTRY_W-1:0] head;
    logic              full;
    logic              empty;

    // Conservative credit: a pop in this cycle does not free a slot yet.
    assign credit = (32'(count) + 32'(inflight_q)) < DEPTH;

    always_comb begin
        state_d      = state_q;
        pc_ce        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        imem_rd      = 1'b0;
        imem_addr    = pc;
        fetch        = 1'b0;
        redirect_run = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_BOOT: begin
                    pc_ce        = 1'b1;
                    pc_load      = 1'b1;
                    pc_load_addr = RESET_PC;
                    state_d      = ST_RUN;
                end
                ST_RUN: begin
                    if (redirect) begin
                        redirect_run = 1'b1;
                        pc_ce        = 1'b1;
                        pc_load      = 1'b1;
                        pc_load_addr = redirect_addr;
                    end else if (credit) begin
                        fetch   = 1'b1;
                        imem_rd = 1'b1;
                        pc_ce   = 1'b1;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // A redirect kills the response arriving in its own cycle.
    assign resp_live = inflight_q && !redirect_run && !reset;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = resp_live && empty;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !reset && !redirect_run && (!empty || bypass);
    assign pop       = out_valid && out_ready && !empty;
    assign push      = resp_live && !(bypass && out_ready);

    always_comb begin
        {out_instr, out_pc} = head;
        if (bypass) begin
            {out_instr, out_pc} = {imem_data, tag_q};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fetch;
            if (fetch) begin
                tag_q <= pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_run),
        .wdata ({imem_data, tag_q}),
        .count (count),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Credit accounting must never push into a full queue without a pop.
    always @(posedge clock) begin
        if (!reset && push && !pop) begin
            assert (!full);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned       ADDR_W   = ADDR_W_DEF;
    localparam int unsigned       INSTR_W  = INSTR_W_DEF;
    localparam int unsigned       DEPTH    = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  cnt = ADDR_W'('h0AB);
    logic               pc_ce, pc_load, imem_rd, out_valid;
    logic [ADDR_W-1:0]  pc_load_addr, imem_addr, out_pc;
    logic [INSTR_W-1:0] imem_data = '0;
    logic [INSTR_W-1:0] out_instr;
    logic               redirect = 1'b0;
    logic [ADDR_W-1:0]  redirect_addr = '0;
    logic               out_ready = 1'b1;

    fetch_queue #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (cnt),
        .pc_ce         (pc_ce),
        .pc_load       (pc_load),
        .pc_load_addr  (pc_load_addr),
        .imem_rd       (imem_rd),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_5500 ^ (32'(a) << 16) ^ 32'(~a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected queue contents plus one pending response.
    typedef enum {MBoot, MRun} mphase_e;
    mphase_e           phase = MBoot;
    fetch_entry_t      mq[$];
    bit                pend = 0;
    logic [ADDR_W-1:0] pend_pc = '0;
    logic [ADDR_W-1:0] hs_log[$];

    // Values sampled at the falling edge, consumed at the next rising edge.
    logic              s_reset = 1'b1, s_redirect = 1'b0, s_rd = 1'b0, s_pop = 1'b0;
    logic              s_byp_take = 1'b0;
    logic [ADDR_W-1:0] s_pc = '0;
    logic              s_ce_dut = 1'b0, s_load_dut = 1'b0, s_rd_dut = 1'b0;
    logic [ADDR_W-1:0] s_laddr_dut = '0, s_addr_dut = '0;

    always @(negedge clock) begin : compare
        logic              e_ce, e_load, e_rd, e_valid, byp;
        logic [ADDR_W-1:0] e_laddr;
        fetch_entry_t      e_head;
        e_ce = 0; e_load = 0; e_rd = 0; e_valid = 0; byp = 0; e_laddr = '0; e_head = '0;
        if (reset) begin
            // everything idle
        end else if (phase == MBoot) begin
            e_ce = 1; e_load = 1; e_laddr = RESET_PC;
        end else if (redirect) begin
            e_ce = 1; e_load = 1; e_laddr = redirect_addr;
        end else begin
            if (mq.size() + int'(pend) < DEPTH) begin
                e_rd = 1; e_ce = 1;
            end
            if (mq.size() != 0) begin
                e_valid = 1; e_head = mq[0];
            end
`ifdef FETCH_QUEUE_BYPASS_EN
            else if (pend) begin
                e_valid = 1; byp = 1;
                e_head = '{instr: mem_word(pend_pc), pc: pend_pc};
            end
`endif
        end
        check("pc_ce", pc_ce, e_ce);
        check("pc_load", pc_load, e_load);
        if (reset || e_load) check("pc_load_addr", pc_load_addr, e_laddr);
        check("imem_rd", imem_rd, e_rd);
        if (e_rd) check("imem_addr", imem_addr, cnt);
        check("out_valid", out_valid, e_valid);
        if (e_valid) begin
            check("out_pc", out_pc, e_head.pc);
            check("out_instr", out_instr, e_head.instr);
        end
        if (out_valid && out_ready) hs_log.push_back(out_pc);
        s_reset = reset; s_redirect = redirect; s_rd = e_rd; s_pc = cnt;
        s_pop = e_valid && out_ready && !byp;
        s_byp_take = byp && out_ready;
        s_ce_dut = pc_ce; s_load_dut = pc_load; s_laddr_dut = pc_load_addr;
        s_rd_dut = imem_rd; s_addr_dut = imem_addr;
    end

    // Environment: program counter and instruction memory.
    always @(posedge clock) begin
        if (s_load_dut) cnt <= s_laddr_dut;
        else if (s_ce_dut) cnt <= cnt + ADDR_W'(1);
        imem_data <= s_rd_dut ? mem_word(s_addr_dut) : INSTR_W'($urandom);
    end

    always @(posedge clock) begin : model
        if (s_reset) begin
            mq.delete(); pend = 0; phase = MBoot;
        end else if (phase == MBoot) begin
            phase = MRun; pend = 0;
        end else begin
            if (s_redirect) begin
                mq.delete();
            end else begin
                if (s_pop) void'(mq.pop_front());
                if (pend && !s_byp_take)
                    mq.push_back('{instr: mem_word(pend_pc), pc: pend_pc});
            end
            pend = s_rd; pend_pc = s_pc;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : stim
        int first_valid;
        int nf;
        out_ready = 1; reset = 1;
        repeat (3) next_cycle();

        // Boot then streaming fetch with decode always ready.
        reset = 0; hs_log.delete();
        @(negedge clock);
        check("boot pc_load", pc_load, 1);
        check("boot load addr", pc_load_addr, RESET_PC);
        check("boot imem_rd", imem_rd, 0);
        first_valid = -1;
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            @(negedge clock);
            if (i == 1) begin
                check("first fetch rd", imem_rd, 1);
                check("first fetch addr", imem_addr, 0);
            end
            if (out_valid && first_valid < 0) first_valid = i;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        check("first out_valid cycle", first_valid, 2);
`else
        check("first out_valid cycle", first_valid, 3);
`endif
        for (int i = 0; i < 4; i++) check("stream out_pc", hs_log[i], i);

        // Mid-run reset, then a stall from empty: exactly DEPTH fetches.
        next_cycle(); reset = 1; out_ready = 0;
        next_cycle();
        next_cycle(); reset = 0;
        nf = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            @(negedge clock);
            if (imem_rd) nf++;
        end
        check("stall fetch count", nf, DEPTH);
        check("stall pc_ce", pc_ce, 0);
        check("stall imem_rd", imem_rd, 0);
        next_cycle(); out_ready = 1; hs_log.delete();
        repeat (12) next_cycle();
        @(negedge clock);
        for (int i = 0; i < 8; i++) check("drain out_pc", hs_log[i], i);

        // Redirect with three entries queued and one read in flight.
        next_cycle(); out_ready = 0; redirect = 1; redirect_addr = 9'h100;
        next_cycle(); redirect = 0;
        repeat (3) next_cycle();
        @(negedge clock);
        check("queued head valid", out_valid, 1);
        check("queued head pc", out_pc, 9'h100);
        next_cycle(); redirect = 1; redirect_addr = 9'h1A0;
        @(negedge clock);
        check("redirect out_valid", out_valid, 0);
        check("redirect pc_load", pc_load, 1);
        check("redirect load addr", pc_load_addr, 9'h1A0);
        check("redirect imem_rd", imem_rd, 0);
        next_cycle(); redirect = 0; out_ready = 1; hs_log.delete();
        repeat (6) next_cycle();
        @(negedge clock);
        check("after redirect pc0", hs_log[0], 9'h1A0);
        check("after redirect pc1", hs_log[1], 9'h1A1);

        // Redirect colliding with a ready handshake.
        next_cycle(); redirect = 1; redirect_addr = 9'h050; hs_log.delete();
        @(negedge clock);
        check("collide out_valid", out_valid, 0);
        next_cycle(); redirect = 0;
        @(negedge clock);
        check("collide queue empty", out_valid, 0);
        repeat (5) next_cycle();
        @(negedge clock);
        check("collide next pc", hs_log[0], 9'h050);

        // PC wrap at 2^ADDR_W.
        next_cycle(); redirect = 1; redirect_addr = 9'h1FE;
        next_cycle(); redirect = 0; hs_log.delete();
        repeat (8) next_cycle();
        @(negedge clock);
        check("wrap pc0", hs_log[0], 9'h1FE);
        check("wrap pc1", hs_log[1], 9'h1FF);
        check("wrap pc2", hs_log[2], 9'h000);
        check("wrap pc3", hs_log[3], 9'h001);

        // Reset with the queue full.
        next_cycle(); out_ready = 0;
        repeat (8) next_cycle();
        @(negedge clock);
        check("full out_valid", out_valid, 1);
        check("full imem_rd", imem_rd, 0);
        next_cycle(); reset = 1;
        next_cycle();
        @(negedge clock);
        check("in reset out_valid", out_valid, 0);
        check("in reset imem_rd", imem_rd, 0);
        check("in reset pc_ce", pc_ce, 0);
        next_cycle(); reset = 0;
        @(negedge clock);
        check("reboot pc_load", pc_load, 1);
        check("reboot load addr", pc_load_addr, RESET_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            next_cycle();
            reset = ($urandom_range(0, 99) == 0);
            redirect = !reset && ($urandom_range(0, 19) == 0);
            redirect_addr = ADDR_W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        next_cycle(); reset = 0; redirect = 0; out_ready = 1;
        repeat (4) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
